serial_ripple_subtractor: RTL and testbench

//   Bit-serial ripple-borrow subtractor; the inverse of the team's ripple-carry adder.

---
 rtl/serial_ripple_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_ripple_subtractor.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/serial_ripple_subtractor.sv
// serial_ripple_subtractor: bit-serial ripple-borrow subtractor.
// Produces diff = (a - b - bin) mod 2^WIDTH and borrow-out over WIDTH bit
// cycles using one full-subtractor cell and a registered borrow.
// Start/busy/done handshake; results are published only in DONE.
// Optional feature macro: OVERFLOW_DETECT_EN adds a registered signed
// overflow flag (ovf) that updates together with diff.
module serial_ripple_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef OVERFLOW_DETECT_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;   // bits already produced; newest enters MSB-side
    logic             br;
    logic [CW-1:0]    cnt;
`ifdef OVERFLOW_DETECT_EN
    logic             a_msb;    // operand sign bits, shifted out of a_sr/b_sr early
    logic             b_msb;
`endif

    logic             a0, b0, d, br_nxt;
    logic [WIDTH-1:0] res_nxt;

    // Full-subtractor cell on the current LSBs plus the incoming borrow
    always_comb begin
        a0      = a_sr[0];
        b0      = b_sr[0];
        d       = a0 ^ b0 ^ br;
        br_nxt  = (~a0 & b0) | (~(a0 ^ b0) & br);
        res_nxt = {d, res_sr};
    end

    // Handshake FSM and serial datapath; outputs only move on the final bit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            br     <= 1'b0;
            cnt    <= '0;
`ifdef OVERFLOW_DETECT_EN
            ovf    <= 1'b0;
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= BUSY;
                        busy   <= 1'b1;
                        a_sr   <= a;
                        b_sr   <= b;
                        br     <= bin;
                        res_sr <= '0;
                        cnt    <= '0;
`ifdef OVERFLOW_DETECT_EN
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    // start is deliberately ignored here
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    br     <= br_nxt;
                    res_sr <= res_nxt[WIDTH-1:1];
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= res_nxt;
                        bout  <= br_nxt;
`ifdef OVERFLOW_DETECT_EN
                        ovf   <= (a_msb != b_msb) && (d != a_msb);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed self-checking bench for serial_ripple_subtractor (WIDTH=4).
// Build with +define+OVERFLOW_DETECT_EN to also exercise the ovf flag.
module tb_serial_ripple_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] a = '0;
    logic [3:0] b = '0;
    logic       bin = 1'b0;
    logic       busy, done, bout;
    logic [3:0] diff;
`ifdef OVERFLOW_DETECT_EN
    logic       ovf;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    serial_ripple_subtractor #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef OVERFLOW_DETECT_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    // Drive one start pulse; returns at the negedge right after the accept edge
    task automatic launch(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin);
        @(negedge clk);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedges until done is seen (bounded); also counts busy samples
    task automatic wait_done(output int cyc, output int nbusy);
        cyc = 0; nbusy = 0;
        while (done !== 1'b1 && cyc < 20) begin
            if (busy === 1'b1) nbusy++;
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #3;
        n_checks++;
        if ({busy, done, diff, bout} !== 7'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b exp 0", {busy, done, diff, bout});
        end
`ifdef OVERFLOW_DETECT_EN
        n_checks++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b exp 0", ovf); end
`endif
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_reset: busy %b done %b exp 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        int cyc, nb;
        logic [3:0] va [6] = '{4'd9, 4'd3, 4'd0, 4'd15, 4'd7, 4'd5};
        logic [3:0] vb [6] = '{4'd3, 4'd9, 4'd0, 4'd0,  4'd7, 4'd9};
        logic       vi [6] = '{1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b1};
        logic [3:0] ed [6] = '{4'd6, 4'hA, 4'hF, 4'hF,  4'd0, 4'hB};
        logic       eb [6] = '{1'b0, 1'b1, 1'b1, 1'b0,  1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            launch(va[i], vb[i], vi[i]);
            wait_done(cyc, nb);
            n_checks++;
            if (cyc !== 4 || nb !== 4) begin
                n_fail++; $display("FAIL latency[%0d]: done after %0d busy %0d exp 4 4", i, cyc, nb);
            end
            n_checks++;
            if (diff !== ed[i] || bout !== eb[i]) begin
                n_fail++; $display("FAIL result[%0d]: diff %h bout %b exp %h %b", i, diff, bout, ed[i], eb[i]);
            end
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || diff !== ed[i]) begin
                n_fail++; $display("FAIL done_pulse[%0d]: done %b diff %h exp 0 %h", i, done, diff, ed[i]);
            end
        end
    endtask

    task automatic test_start_in_busy;
        int cyc, nb, ndone;
        launch(4'd5, 4'd2, 1'b0);
        a = 4'd15; b = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(cyc, nb);
        n_checks++;
        if (cyc !== 3 || diff !== 4'd3 || bout !== 1'b0) begin
            n_fail++; $display("FAIL start_in_busy: cyc %0d diff %h bout %b exp 3 3 0", cyc, diff, bout);
        end
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin n_fail++; $display("FAIL extra_done: got %0d exp 0", ndone); end
    endtask

    task automatic test_back_to_back;
        int cyc, nb;
        launch(4'd9, 4'd3, 1'b0);
        wait_done(cyc, nb);
        a = 4'd7; b = 4'd7; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1 || diff !== 4'd6) begin
            n_fail++; $display("FAIL b2b_accept: done %b busy %b diff %h exp 0 1 6", done, busy, diff);
        end
        wait_done(cyc, nb);
        n_checks++;
        if (cyc + 1 !== 5 || diff !== 4'd0 || bout !== 1'b0) begin
            n_fail++; $display("FAIL b2b_result: gap %0d diff %h bout %b exp 5 0 0", cyc + 1, diff, bout);
        end
    endtask

    task automatic test_reset_mid;
        int ndone;
        launch(4'd3, 4'd9, 1'b0);
        wait_done(ndone, ndone);   // leaves diff = A as a nonzero prior result
        launch(4'd9, 4'd3, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, diff, bout} !== 7'b0) begin
            n_fail++; $display("FAIL reset_mid: got %b exp 0", {busy, done, diff, bout});
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin n_fail++; $display("FAIL after_abort: activity %0d exp 0", ndone); end
    endtask

`ifdef OVERFLOW_DETECT_EN
    task automatic test_ovf;
        int cyc, nb;
        launch(4'd8, 4'd1, 1'b0);
        wait_done(cyc, nb);
        n_checks++;
        if (diff !== 4'd7 || ovf !== 1'b1) begin
            n_fail++; $display("FAIL ovf_set: diff %h ovf %b exp 7 1", diff, ovf);
        end
        launch(4'd5, 4'd2, 1'b0);
        n_checks++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_hold: got %b exp 1", ovf); end
        wait_done(cyc, nb);
        n_checks++;
        if (diff !== 4'd3 || ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_clear: diff %h ovf %b exp 3 0", diff, ovf);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_start_in_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef OVERFLOW_DETECT_EN
        test_ovf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
